fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding imem handshake, PC sequencing,
// misprediction redirect and pipeline stall/kill generation for IF/ID/DP.
module fetch_ctrl #(
    parameter logic [31:0] ENTRY_POINT  = 32'h8000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_valid_i,
    output logic        imem_resp_ready_o,
    input  logic        dp_stall_i,
    input  logic        mispred_i,
    input  logic [31:0] redirect_pc_i,
    output logic        stall_IF_o,
    output logic        kill_IF_o,
    output logic        stall_ID_o,
    output logic        kill_ID_o,
    output logic        stall_DP_o,
    output logic        kill_DP_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        outst_q;
    logic [3:0]  cnt_q;

    logic kill;
    logic resp_ready;
    logic accept;
    logic req;

    // Handshake outputs depend on dp_stall_i/mispred_i in the same cycle, so
    // they are decoded combinationally from the registered state.
    always_comb begin
        kill       = mispred_i | (state_q == S_FLUSH);
        req        = (state_q == S_REQ) & ~dp_stall_i & ~mispred_i;
        resp_ready = ((state_q == S_RESP) & ~dp_stall_i) | (state_q == S_FLUSH);
        accept     = imem_valid_i & resp_ready;
    end

    assign imem_req_o        = req;
    assign imem_addr_o       = pc_q;
    assign imem_resp_ready_o = resp_ready;
    assign stall_IF_o        = ~((state_q == S_RESP) & accept);
    assign kill_IF_o         = kill;
    assign kill_ID_o         = kill;
    assign kill_DP_o         = kill;
    assign stall_ID_o        = dp_stall_i & ~kill;
    assign stall_DP_o        = dp_stall_i & ~kill;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            pc_q    <= ENTRY_POINT;
            outst_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else if (mispred_i) begin
            // Redirect wins over everything; a same-cycle response is drained and dropped.
            state_q <= S_FLUSH;
            pc_q    <= redirect_pc_i;
            cnt_q   <= 4'(FLUSH_CYCLES);
            if (accept)
                outst_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (req && imem_ready_i) begin
                        outst_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (accept) begin
                        pc_q    <= pc_q + 32'd4;
                        outst_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (accept)
                        outst_q <= 1'b0;
                    if (cnt_q != 4'd0)
                        cnt_q <= cnt_q - 4'd1;
                    // Stay until the in-flight response has been swallowed.
                    if (cnt_q == 4'd0 && !outst_q)
                        state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: request addresses are queued as expected when
// the stimulus is set up and popped as the DUT issues handshakes.
module tb_fetch_ctrl;

    localparam logic [31:0] EP = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n, imem_req, imem_ready, imem_valid, imem_resp_ready;
    logic        dp_stall, mispred;
    logic [31:0] imem_addr, redirect_pc;
    logic        stall_IF, kill_IF, stall_ID, kill_ID, stall_DP, kill_DP;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    fetch_ctrl #(.ENTRY_POINT(EP), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_valid_i(imem_valid), .imem_resp_ready_o(imem_resp_ready),
        .dp_stall_i(dp_stall), .mispred_i(mispred), .redirect_pc_i(redirect_pc),
        .stall_IF_o(stall_IF), .kill_IF_o(kill_IF), .stall_ID_o(stall_ID),
        .kill_ID_o(kill_ID), .stall_DP_o(stall_DP), .kill_DP_o(kill_DP)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Sample point: any accepted request must match the head of the expected queue.
    task automatic smp();
        logic [31:0] e;
        @(negedge clk);
        if (imem_req && imem_ready) begin
            tests++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("FAIL unexpected_req: observed addr %h expected no request", imem_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("req_addr", imem_addr, e);
            end
        end
    endtask

    task automatic req_cycle(input logic [31:0] addr);
        exp_q.push_back(addr);
        smp();
        chk("req_issued_qlen", 32'(exp_q.size()), 32'd0);
        chk("req_stall_IF", {31'd0, stall_IF}, 32'd1);
    endtask

    task automatic chk_kills(input string tag, input logic k);
        chk(tag, {29'd0, kill_IF, kill_ID, kill_DP}, {29'd0, k, k, k});
    endtask

    initial begin
        reset_n = 1'b0; dp_stall = 1'b1; imem_ready = 1'b1; imem_valid = 1'b1;
        mispred = 1'b0; redirect_pc = 32'd0;
        nxt(); smp();
        nxt(); smp();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, EP);
        chk("rst_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        chk("rst_stall_IF", {31'd0, stall_IF}, 32'd1);
        chk_kills("rst_kills", 1'b0);
        chk("rst_stall_ID_DP", {30'd0, stall_ID, stall_DP}, 32'd3);
        reset_n = 1'b1; dp_stall = 1'b0;

        // Back-to-back fetches, stall_IF drops every second cycle
        for (int i = 0; i < 3; i++) begin
            nxt(); req_cycle(EP + 32'(4 * i));
            nxt(); smp();
            chk("seq_stall_IF_acc", {31'd0, stall_IF}, 32'd0);
        end

        // Slow response: stall held, address stable, no second request
        nxt(); imem_valid = 1'b0; req_cycle(EP + 32'h0C);
        for (int i = 0; i < 5; i++) begin
            nxt(); smp();
            chk("wait_stall_IF", {31'd0, stall_IF}, 32'd1);
            chk("wait_addr", imem_addr, EP + 32'h0C);
            chk("wait_req", {31'd0, imem_req}, 32'd0);
        end
        nxt(); imem_valid = 1'b1; smp();
        chk("wait_acc_stall_IF", {31'd0, stall_IF}, 32'd0);

        // Dispatch backpressure holds the response
        nxt(); req_cycle(EP + 32'h10);
        for (int i = 0; i < 3; i++) begin
            nxt(); dp_stall = 1'b1; smp();
            chk("bp_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
            chk("bp_stall_IF", {31'd0, stall_IF}, 32'd1);
            chk("bp_stall_ID", {31'd0, stall_ID}, 32'd1);
        end
        nxt(); dp_stall = 1'b0; smp();
        chk("bp_resp_ready_acc", {31'd0, imem_resp_ready}, 32'd1);
        chk("bp_stall_IF_acc", {31'd0, stall_IF}, 32'd0);

        // Mispredict in S_RESP, late response is drained and discarded
        nxt(); imem_valid = 1'b0; req_cycle(EP + 32'h14);
        nxt(); mispred = 1'b1; redirect_pc = EP + 32'h100; smp();
        chk_kills("mp_kills", 1'b1);
        chk("mp_req", {31'd0, imem_req}, 32'd0);
        nxt(); mispred = 1'b0; smp();
        chk_kills("fl_kills1", 1'b1);
        chk("fl_resp_ready", {31'd0, imem_resp_ready}, 32'd1);
        chk("fl_addr", imem_addr, EP + 32'h100);
        nxt(); dp_stall = 1'b1; smp();
        chk_kills("fl_kills2", 1'b1);
        chk("fl_stall_ID_DP", {30'd0, stall_ID, stall_DP}, 32'd0);
        nxt(); dp_stall = 1'b0; smp();
        chk_kills("fl_kills3", 1'b1);
        nxt(); imem_valid = 1'b1; smp();
        chk_kills("fl_kills_drain", 1'b1);
        chk("fl_drain_stall_IF", {31'd0, stall_IF}, 32'd1);
        nxt(); imem_valid = 1'b0; smp();
        chk_kills("fl_kills_last", 1'b1);
        nxt(); req_cycle(EP + 32'h100);
        chk_kills("fl_exit_kills", 1'b0);

        // Mispredict with same-cycle response, then a second one mid-flush
        nxt(); mispred = 1'b1; redirect_pc = EP + 32'h180; imem_valid = 1'b1; smp();
        chk_kills("mp2_kills", 1'b1);
        nxt(); mispred = 1'b0; imem_valid = 1'b0; smp();
        chk_kills("mp2_fl1", 1'b1);
        nxt(); mispred = 1'b1; redirect_pc = EP + 32'h200; smp();
        chk_kills("mp3_kills", 1'b1);
        for (int i = 0; i < 3; i++) begin
            nxt(); mispred = 1'b0; smp();
            chk_kills("mp3_ext_kills", 1'b1);
            chk("mp3_ext_req", {31'd0, imem_req}, 32'd0);
        end
        nxt(); req_cycle(EP + 32'h200);
        chk_kills("mp3_exit_kills", 1'b0);

        // Reset in the middle of a flush
        nxt(); mispred = 1'b1; redirect_pc = EP + 32'h300; smp();
        nxt(); mispred = 1'b0; reset_n = 1'b0; smp();
        chk_kills("rstfl_pre_kills", 1'b1);
        nxt(); reset_n = 1'b1; smp();
        chk_kills("rstfl_kills", 1'b0);
        chk("rstfl_addr", imem_addr, EP);
        chk("rstfl_req", {31'd0, imem_req}, 32'd0);
        chk("rstfl_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
        chk("rstfl_stall_IF", {31'd0, stall_IF}, 32'd1);
        nxt(); dp_stall = 1'b1; smp();
        chk("req_dp_stall", {31'd0, imem_req}, 32'd0);
        nxt(); dp_stall = 1'b0; req_cycle(EP);
        nxt(); imem_valid = 1'b1; smp();
        chk("rst_refetch_acc", {31'd0, stall_IF}, 32'd0);

        // Mispredict straight out of reset-forced S_IDLE
        nxt(); dp_stall = 1'b1; imem_valid = 1'b0; reset_n = 1'b0; smp();
        nxt(); reset_n = 1'b1; dp_stall = 1'b0; mispred = 1'b1; redirect_pc = EP + 32'h400; smp();
        chk_kills("idle_mp_kills", 1'b1);
        chk("idle_mp_req", {31'd0, imem_req}, 32'd0);
        nxt(); mispred = 1'b0; smp();
        chk("idle_mp_addr", imem_addr, EP + 32'h400);
        for (int i = 0; i < 2; i++) begin
            nxt(); smp();
            chk_kills("idle_mp_fl_kills", 1'b1);
        end
        nxt(); req_cycle(EP + 32'h400);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
